// File: rtl/multicycle_control.sv
// Main control unit for a multicycle RV32I-style datapath: a Moore FSM
// that sequences fetch, decode, memory, ALU and branch steps per instruction.
module multicycle_control #(
   parameter bit ILLEGAL_HALT = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   input  logic       branch_taken,
   output logic       pc_write,
   output logic       ir_write,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       reg_write,
   output logic       pc_src,
   output logic       illegal_instr,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] result_src,
   output logic [3:0] state
);

   // state    | meaning
   // FETCH    | read instruction at PC, PC <= PC+4 when memory answers
   // DECODE   | decode opcode, compute PC-relative target into ALUOut
   // MEMADR   | compute load/store address rs1+imm
   // MEMREAD  | load request, wait for memory
   // MEMWB    | write loaded data to rd
   // MEMWRITE | store request, wait for memory
   // EXEC_R   | register-register ALU operation
   // EXEC_I   | register-immediate ALU operation
   // ALUWB    | write ALUOut to rd
   // BRANCH   | compare rs1/rs2, take target from ALUOut if true
   // JAL      | rd <= old_pc+4, PC <= ALUOut
   // JALR     | compute rs1+imm target into ALUOut, then reuse JAL
   // LUI      | 0 + imm
   // AUIPC    | old_pc + imm
   // TRAP     | unsupported opcode
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXEC_R   = 4'd6,
      S_EXEC_I   = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_LUI      = 4'd12,
      S_AUIPC    = 4'd13,
      S_TRAP     = 4'd15
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;
   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;
   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_CMP    = 2'b01;
   localparam logic [1:0] ALU_FUNCT  = 2'b10;
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   state_t state_q, state_d;

   logic pc_write_c, ir_write_c, mem_req_c, mem_we_c, iord_c;
   logic reg_write_c, pc_src_c, illegal_c;

   function automatic state_t decode_next(input logic [6:0] op);
      state_t nxt;
      case (op)
         OP_LOAD, OP_STORE: nxt = S_MEMADR;
         OP_R:              nxt = S_EXEC_R;
         OP_I:              nxt = S_EXEC_I;
         OP_BRANCH:         nxt = S_BRANCH;
         OP_JAL:            nxt = S_JAL;
         OP_JALR:           nxt = S_JALR;
         OP_LUI:            nxt = S_LUI;
         OP_AUIPC:          nxt = S_AUIPC;
         default:           nxt = S_TRAP;
      endcase
      return nxt;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_write_c  = 1'b0;
      ir_write_c  = 1'b0;
      mem_req_c   = 1'b0;
      mem_we_c    = 1'b0;
      iord_c      = 1'b0;
      reg_write_c = 1'b0;
      pc_src_c    = 1'b0;
      illegal_c   = 1'b0;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_RS2;
      alu_op      = ALU_ADD;
      result_src  = RES_ALUOUT;

      case (state_q)
         S_FETCH: begin
            mem_req_c  = 1'b1;
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_FOUR;
            ir_write_c = mem_ready;
            pc_write_c = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            state_d   = decode_next(opcode);
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            state_d   = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            mem_req_c = 1'b1;
            iord_c    = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            result_src  = RES_MEM;
            reg_write_c = 1'b1;
            state_d     = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req_c = 1'b1;
            mem_we_c  = 1'b1;
            iord_c    = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXEC_R: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_RS2;
            alu_op    = ALU_FUNCT;
            state_d   = S_ALUWB;
         end
         S_EXEC_I: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_FUNCT;
            state_d   = S_ALUWB;
         end
         S_LUI: begin
            alu_src_a = SRCA_ZERO;
            alu_src_b = SRCB_IMM;
            state_d   = S_ALUWB;
         end
         S_AUIPC: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            result_src  = RES_ALUOUT;
            reg_write_c = 1'b1;
            state_d     = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_RS2;
            alu_op     = ALU_CMP;
            pc_src_c   = 1'b1;
            pc_write_c = branch_taken;
            state_d    = S_FETCH;
         end
         S_JALR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            state_d   = S_JAL;
         end
         S_JAL: begin
            alu_src_a   = SRCA_OLDPC;
            alu_src_b   = SRCB_FOUR;
            result_src  = RES_ALU;
            reg_write_c = 1'b1;
            pc_src_c    = 1'b1;
            pc_write_c  = 1'b1;
            state_d     = S_FETCH;
         end
         S_TRAP: begin
            illegal_c = 1'b1;
            state_d   = ILLEGAL_HALT ? S_TRAP : S_FETCH;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // Enables are gated by rst_n so a reset kills a pending request within the same cycle.
   assign pc_write      = pc_write_c  & rst_n;
   assign ir_write      = ir_write_c  & rst_n;
   assign mem_req       = mem_req_c   & rst_n;
   assign mem_we        = mem_we_c    & rst_n;
   assign reg_write     = reg_write_c & rst_n;
   assign illegal_instr = illegal_c   & rst_n;
   assign iord          = iord_c;
   assign pc_src        = pc_src_c;
   assign state         = state_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter: ILLEGAL_HALT, default 1, meaning 1 = remain in TRAP, 0 = return to FETCH after one TRAP cycle.
REQ-002 SHALL have port: clk  input  1  the single clock; all state updates occur on the rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: opcode  input  7  instruction[6:0] from the instruction register.
REQ-005 SHALL have port: mem_ready  input  1  memory completes the current request.
REQ-006 SHALL have port: branch_taken  input  1  datapath comparator result for the current funct3.
REQ-007 SHALL have outputs, each 1 bit: pc_write, ir_write, mem_req, mem_we, iord (0 = PC address, 1 = ALUOut address), reg_write, pc_src (0 = ALU result, 1 = ALUOut register), illegal_instr.
REQ-008 SHALL have outputs, each 2 bits: alu_src_a (00 PC, 01 old_pc, 10 rs1, 11 zero), alu_src_b (00 rs2, 01 immediate, 10 constant 4), alu_op (00 add, 01 compare/subtract, 10 funct-decoded), result_src (00 ALUOut, 01 memory data, 10 ALU result).
REQ-009 SHALL have output: state  4 bits  current state, for debug.

Function
REQ-010 SHALL implement a Moore FSM with these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, LUI=12, AUIPC=13, TRAP=15.
REQ-011 SHALL drive every output that a state below does not list to 0 / 00.
REQ-012 FETCH SHALL drive: mem_req=1, alu_src_a=00, alu_src_b=10, alu_op=00, pc_src=0, and ir_write=pc_write=mem_ready; it SHALL stay in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-013 DECODE SHALL drive alu_src_a=01, alu_src_b=01, alu_op=00, so the branch/JAL target is captured into ALUOut.
REQ-014 DECODE SHALL select the next state from opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI; 0010111 -> AUIPC; any other opcode -> TRAP.
REQ-015 MEMADR SHALL drive alu_src_a=10, alu_src_b=01, alu_op=00, then go to MEMREAD if opcode=0000011 and to MEMWRITE otherwise.
REQ-016 MEMREAD SHALL drive mem_req=1 and iord=1, and SHALL wait for mem_ready=1 before going to MEMWB; MEMWB SHALL drive result_src=01 and reg_write=1, then go to FETCH.
REQ-017 MEMWRITE SHALL drive mem_req=1, mem_we=1 and iord=1, and SHALL wait for mem_ready=1 before going to FETCH.
REQ-018 EXEC_R SHALL drive alu_src_a=10, alu_src_b=00, alu_op=10; EXEC_I SHALL drive alu_src_a=10, alu_src_b=01, alu_op=10; LUI SHALL drive alu_src_a=11, alu_src_b=01, alu_op=00; AUIPC SHALL drive alu_src_a=01, alu_src_b=01, alu_op=00; each of these four SHALL go to ALUWB.
REQ-019 ALUWB SHALL drive result_src=00 and reg_write=1, then go to FETCH.
REQ-020 BRANCH SHALL drive alu_src_a=10, alu_src_b=00, alu_op=01, pc_src=1 and pc_write=branch_taken, then go to FETCH.
REQ-021 JALR SHALL drive alu_src_a=10, alu_src_b=01, alu_op=00 (target into ALUOut) and go to JAL; target bit-0 clearing is performed by the datapath.
REQ-022 JAL SHALL drive alu_src_a=01, alu_src_b=10, alu_op=00, result_src=10, reg_write=1, pc_src=1 and pc_write=1, then go to FETCH.
REQ-023 TRAP SHALL drive illegal_instr=1; the next state SHALL be TRAP when ILLEGAL_HALT=1 and FETCH when ILLEGAL_HALT=0.
REQ-024 Handshake: mem_req, mem_we and iord SHALL stay stable until the cycle in which mem_ready=1, and mem_ready SHALL be ignored in all non-memory states.
REQ-025 opcode SHALL be sampled only in DECODE and MEMADR.
REQ-026 Instruction latency in cycles, with zero memory wait, SHALL be: R/I/LUI/AUIPC 4, load 5, store 4, branch 3, JAL 3, JALR 4.

Reset
REQ-027 While rst_n=0, state SHALL be FETCH and all enable outputs (pc_write, ir_write, mem_req, mem_we, reg_write, illegal_instr) SHALL be forced to 0.
REQ-028 Reset assertion mid-transaction SHALL take effect immediately and abort any pending memory request.
REQ-029 The first rising edge after rst_n deasserts SHALL evaluate FETCH normally.

Verification
REQ-030 addi (opcode 0010011) with mem_ready=1 -> states 0,1,7,8,0; reg_write high only in ALUWB; pc_write and ir_write high only in FETCH.
REQ-031 lw with mem_ready low for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0; mem_req and iord held at 1 throughout MEMREAD.
REQ-032 beq with branch_taken=0, then a repeat with branch_taken=1 -> BRANCH pc_write is 0 then 1, with pc_src=1 in both runs.
REQ-033 jalr -> states 0,1,11,10,0; in JAL, reg_write=pc_write=1 and result_src=10.
REQ-034 opcode 0000000 -> TRAP with illegal_instr=1, held for 5 cycles when ILLEGAL_HALT=1; a single TRAP cycle then FETCH when ILLEGAL_HALT=0.
REQ-035 rst_n pulled low during MEMWRITE while mem_ready=0 -> mem_req and mem_we go to 0 asynchronously and state=0.
